// File: rtl/ram_latency_responder_if.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg + ram_latency_responder_if
//
// Purpose:
//   cpu_types_pkg holds the shared RAM state encoding (ramstate_t).
//   ram_latency_responder_if bundles the RAM request/response signals seen
//   between the memory controller and the RAM.
//
// Signals:
//   ramREN   : read request, level (controller -> RAM)
//   ramWEN   : write request, level, wins over ramREN (controller -> RAM)
//   ramaddr  : 32-bit byte address (controller -> RAM)
//   ramstore : 32-bit write data (controller -> RAM)
//   ramload  : 32-bit registered read data (RAM -> controller)
//   ramstate : FREE/BUSY/ACCESS/ERROR (RAM -> controller)
//
// Modports:
//   master : memory controller side
//   slave  : RAM / responder side
// ----------------------------------------------------------------------------
package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

interface ram_latency_responder_if;
    import cpu_types_pkg::*;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    ramstate_t   ramstate;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );
endinterface

// File: rtl/ram_latency_responder.sv
// ----------------------------------------------------------------------------
// ram_latency_responder
//
// Purpose:
//   Word-addressed backing store that answers controller requests after a
//   programmable number of BUSY cycles, reporting progress on ramstate.
//   A request sampled at edge E shows BUSY for LAT cycles and ACCESS in the
//   following cycle; read data is on ramload during that ACCESS cycle.
//   Dropping the request during BUSY aborts it; changing op or address
//   during BUSY restarts the count with the new request. Aborted writes
//   never reach memory. ACCESS/ERROR last one cycle and, if a request is
//   still present, start the next transaction with no FREE gap.
//
// Parameters:
//   LAT   : BUSY cycles per transaction, 0..15 (4-bit counter)
//   DEPTH : store size in 32-bit words, power of two
//
// Ports:
//   CLK : clock, rising edge
//   RST : asynchronous, active-high reset (memory contents survive it)
//   bus : ram_latency_responder_if.slave (ramREN/ramWEN/ramaddr/ramstore in,
//         ramload/ramstate out)
//
// Configuration macro:
//   RAM_BOUNDS_CHECK_EN : when defined, a misaligned address or any set bit
//   above the store's range turns the request into a one-cycle ERROR with
//   ramload = 32'hBAD1BAD1 and no memory access. When undefined, the address
//   simply wraps to ramaddr[AW+1:2].
// ----------------------------------------------------------------------------
module ram_latency_responder #(
    parameter int LAT   = 2,
    parameter int DEPTH = 1024
) (
    input  logic                          CLK,
    input  logic                          RST,
    ram_latency_responder_if.slave        bus
);
    import cpu_types_pkg::*;

    localparam int AW = $clog2(DEPTH);

    // State codes are the ramstate encodings themselves.
    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BUSY   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_ERROR  = 2'd3;

    localparam logic [3:0] LAT_CNT = 4'(LAT);
    // With no BUSY cycles a started transaction lands directly in ACCESS.
    localparam logic [1:0] S_START = (LAT > 0) ? S_BUSY : S_ACCESS;

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic          r_op_wr;
    logic [31:0]   r_addr;
    logic [31:0]   r_store;
    logic [31:0]   r_load;
    logic [31:0]   r_mem [DEPTH] = '{default: 32'h0};

    logic          w_req;
    logic          w_addr_err;
    logic          w_start;
    logic [1:0]    w_nxt_state;
    logic [3:0]    w_nxt_cnt;
    logic          w_acc_wr;
    logic [AW-1:0] w_acc_idx;
    logic [31:0]   w_acc_data;

    assign w_req = bus.ramREN | bus.ramWEN;

`ifdef RAM_BOUNDS_CHECK_EN
    assign w_addr_err = (bus.ramaddr[1:0] != 2'b00) ||
                        ((bus.ramaddr >> (AW + 2)) != 32'h0);
`else
    assign w_addr_err = 1'b0;
`endif

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_start     = 1'b0;
        case (r_state)
            S_FREE: begin
                if (w_req) w_start = 1'b1;
            end
            S_BUSY: begin
                if (!w_req) begin
                    w_nxt_state = S_FREE;
                end else if ((bus.ramWEN != r_op_wr) || (bus.ramaddr != r_addr)) begin
                    w_start = 1'b1;
                end else if (r_cnt <= 4'd1) begin
                    w_nxt_state = S_ACCESS;
                end else begin
                    w_nxt_cnt = r_cnt - 4'd1;
                end
            end
            default: begin
                // ACCESS and ERROR: one cycle, then back-to-back or FREE.
                if (w_req) w_start = 1'b1;
                else       w_nxt_state = S_FREE;
            end
        endcase
        if (w_start) begin
            w_nxt_state = w_addr_err ? S_ERROR : S_START;
            w_nxt_cnt   = LAT_CNT;
        end
    end

    // Operands for an ACCESS entry: a transaction started on this same edge
    // (LAT = 0) uses the live inputs, otherwise the values latched at start.
    assign w_acc_wr   = w_start ? bus.ramWEN              : r_op_wr;
    assign w_acc_idx  = w_start ? bus.ramaddr[AW+1:2]     : r_addr[AW+1:2];
    assign w_acc_data = w_start ? bus.ramstore            : r_store;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: the memory array is deliberately not reset; it is only written in
    // the non-reset branch, so a reset edge discards a pending write while
    // anything already committed stays.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_FREE;
            r_cnt   <= 4'd0;
            r_op_wr <= 1'b0;
            r_addr  <= 32'h0;
            r_store <= 32'h0;
            r_load  <= 32'h0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            if (w_start && !w_addr_err) begin
                r_op_wr <= bus.ramWEN;
                r_addr  <= bus.ramaddr;
                r_store <= bus.ramstore;
            end
            // ACCESS lasts one cycle, so every edge into it is an entry edge.
            if (w_nxt_state == S_ACCESS) begin
                if (w_acc_wr) r_mem[w_acc_idx] <= w_acc_data;
                else          r_load           <= r_mem[w_acc_idx];
            end else if (w_nxt_state == S_ERROR) begin
                r_load <= 32'hBAD1BAD1;
            end
        end
    end

    assign bus.ramload  = r_load;
    assign bus.ramstate = ramstate_t'(r_state);

endmodule

// File: tb/tb_ram_latency_responder.sv
// ----------------------------------------------------------------------------
// tb_ram_latency_responder
//
// Directed bench for ram_latency_responder. Two instances share clock and
// reset: u_lat2 (LAT = 2) for the latency/abort/restart scenarios and u_lat0
// (LAT = 0) for back-to-back streaming. Inputs change 1 time unit after the
// rising edge; outputs are checked at that same point, i.e. they reflect the
// state produced by the edge just taken.
// ----------------------------------------------------------------------------
module tb_ram_latency_responder;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    ram_latency_responder_if if2();
    ram_latency_responder_if if0();

    ram_latency_responder #(.LAT(2), .DEPTH(1024)) u_lat2 (
        .CLK (CLK),
        .RST (RST),
        .bus (if2.slave)
    );

    ram_latency_responder #(.LAT(0), .DEPTH(1024)) u_lat0 (
        .CLK (CLK),
        .RST (RST),
        .bus (if0.slave)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive2(input logic ren, input logic wen,
                          input logic [31:0] addr, input logic [31:0] data);
        if2.ramREN   = ren;
        if2.ramWEN   = wen;
        if2.ramaddr  = addr;
        if2.ramstore = data;
    endtask

    task automatic drive0(input logic ren, input logic wen,
                          input logic [31:0] addr, input logic [31:0] data);
        if0.ramREN   = ren;
        if0.ramWEN   = wen;
        if0.ramaddr  = addr;
        if0.ramstore = data;
    endtask

    // Reset held with a read request pending, then released.
    task automatic test_reset();
        ramstate_t exp_seq [3] = '{BUSY, BUSY, ACCESS};
        drive2(1'b1, 1'b0, 32'h0, 32'h0);
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        #1 RST = 1'b1;
        #1;
        n_total++; if (if2.ramstate !== FREE) $display("FAIL rst_state_async: got %0d want %0d", if2.ramstate, FREE); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (if2.ramstate !== FREE) $display("FAIL rst_state[%0d]: got %0d want %0d", i, if2.ramstate, FREE); else n_pass++;
            n_total++; if (if2.ramload !== 32'h0) $display("FAIL rst_load[%0d]: got %h want %h", i, if2.ramload, 32'h0); else n_pass++;
        end
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (if2.ramstate !== exp_seq[i]) $display("FAIL rst_release_seq[%0d]: got %0d want %0d", i, if2.ramstate, exp_seq[i]); else n_pass++;
        end
        n_total++; if (if2.ramload !== 32'h0) $display("FAIL rst_first_read: got %h want %h", if2.ramload, 32'h0); else n_pass++;
        drive2(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        n_total++; if (if2.ramstate !== FREE) $display("FAIL rst_idle: got %0d want %0d", if2.ramstate, FREE); else n_pass++;
    endtask

    // Write DEADBEEF to 0x40 then read it back with no FREE gap between.
    task automatic test_write_read();
        ramstate_t exp_seq [3] = '{BUSY, BUSY, ACCESS};
        drive2(1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (if2.ramstate !== exp_seq[i]) $display("FAIL wr_seq[%0d]: got %0d want %0d", i, if2.ramstate, exp_seq[i]); else n_pass++;
        end
        n_total++; if (if2.ramload !== 32'h0) $display("FAIL wr_load_held: got %h want %h", if2.ramload, 32'h0); else n_pass++;
        drive2(1'b1, 1'b0, 32'h40, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (if2.ramstate !== exp_seq[i]) $display("FAIL rd_seq[%0d]: got %0d want %0d", i, if2.ramstate, exp_seq[i]); else n_pass++;
        end
        n_total++; if (if2.ramload !== 32'hDEADBEEF) $display("FAIL rd_data_0x40: got %h want %h", if2.ramload, 32'hDEADBEEF); else n_pass++;
        drive2(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        n_total++; if (if2.ramstate !== FREE) $display("FAIL wr_rd_idle: got %0d want %0d", if2.ramstate, FREE); else n_pass++;
    endtask

    // Write to 0x80 dropped during the second BUSY cycle must not commit.
    task automatic test_abort();
        ramstate_t exp_seq [3] = '{BUSY, BUSY, ACCESS};
        drive2(1'b0, 1'b1, 32'h80, 32'h1234);
        step();
        n_total++; if (if2.ramstate !== BUSY) $display("FAIL abort_busy1: got %0d want %0d", if2.ramstate, BUSY); else n_pass++;
        step();
        n_total++; if (if2.ramstate !== BUSY) $display("FAIL abort_busy2: got %0d want %0d", if2.ramstate, BUSY); else n_pass++;
        drive2(1'b0, 1'b0, 32'h80, 32'h1234);
        step();
        n_total++; if (if2.ramstate !== FREE) $display("FAIL abort_free: got %0d want %0d", if2.ramstate, FREE); else n_pass++;
        drive2(1'b1, 1'b0, 32'h80, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (if2.ramstate !== exp_seq[i]) $display("FAIL abort_rd_seq[%0d]: got %0d want %0d", i, if2.ramstate, exp_seq[i]); else n_pass++;
        end
        n_total++; if (if2.ramload !== 32'h0) $display("FAIL abort_rd_0x80: got %h want %h", if2.ramload, 32'h0); else n_pass++;
        drive2(1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    // Read of 0x10 switched to 0x14 mid-BUSY restarts the full latency.
    task automatic test_addr_change();
        drive2(1'b0, 1'b1, 32'h14, 32'hA5A50005);
        repeat (3) step();
        n_total++; if (if2.ramstate !== ACCESS) $display("FAIL chg_prewrite: got %0d want %0d", if2.ramstate, ACCESS); else n_pass++;
        drive2(1'b1, 1'b0, 32'h10, 32'h0);
        step();
        n_total++; if (if2.ramstate !== BUSY) $display("FAIL chg_busy_old: got %0d want %0d", if2.ramstate, BUSY); else n_pass++;
        drive2(1'b1, 1'b0, 32'h14, 32'h0);
        step();
        n_total++; if (if2.ramstate !== BUSY) $display("FAIL chg_restart1: got %0d want %0d", if2.ramstate, BUSY); else n_pass++;
        step();
        n_total++; if (if2.ramstate !== BUSY) $display("FAIL chg_restart2: got %0d want %0d", if2.ramstate, BUSY); else n_pass++;
        step();
        n_total++; if (if2.ramstate !== ACCESS) $display("FAIL chg_access: got %0d want %0d", if2.ramstate, ACCESS); else n_pass++;
        n_total++; if (if2.ramload !== 32'hA5A50005) $display("FAIL chg_data_mem5: got %h want %h", if2.ramload, 32'hA5A50005); else n_pass++;
        drive2(1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    // A continuously held read gives one ACCESS every LAT+1 cycles.
    task automatic test_held_request();
        ramstate_t exp_seq [6] = '{BUSY, BUSY, ACCESS, BUSY, BUSY, ACCESS};
        drive2(1'b1, 1'b0, 32'h40, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            n_total++; if (if2.ramstate !== exp_seq[i]) $display("FAIL held_seq[%0d]: got %0d want %0d", i, if2.ramstate, exp_seq[i]); else n_pass++;
        end
        n_total++; if (if2.ramload !== 32'hDEADBEEF) $display("FAIL held_data: got %h want %h", if2.ramload, 32'hDEADBEEF); else n_pass++;
        drive2(1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    // LAT = 0: streaming writes then reads, ACCESS on every cycle.
    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive0(1'b0, 1'b1, 32'(i * 4), 32'h100 + 32'(i));
            step();
            n_total++; if (if0.ramstate !== ACCESS) $display("FAIL b2b_wr_state[%0d]: got %0d want %0d", i, if0.ramstate, ACCESS); else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            drive0(1'b1, 1'b0, 32'(i * 4), 32'h0);
            step();
            n_total++; if (if0.ramstate !== ACCESS) $display("FAIL b2b_rd_state[%0d]: got %0d want %0d", i, if0.ramstate, ACCESS); else n_pass++;
            n_total++; if (if0.ramload !== 32'h100 + 32'(i)) $display("FAIL b2b_rd_data[%0d]: got %h want %h", i, if0.ramload, 32'h100 + 32'(i)); else n_pass++;
        end
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        n_total++; if (if0.ramstate !== FREE) $display("FAIL b2b_idle: got %0d want %0d", if0.ramstate, FREE); else n_pass++;
    endtask

    // Reset during BUSY of a write: the write is lost, older data survives.
    task automatic test_reset_mid();
        drive2(1'b0, 1'b1, 32'h200, 32'h77);
        step();
        step();
        n_total++; if (if2.ramstate !== BUSY) $display("FAIL rmid_busy: got %0d want %0d", if2.ramstate, BUSY); else n_pass++;
        drive2(1'b0, 1'b0, 32'h0, 32'h0);
        RST = 1'b1;
        #1;
        n_total++; if (if2.ramstate !== FREE) $display("FAIL rmid_async_free: got %0d want %0d", if2.ramstate, FREE); else n_pass++;
        step();
        RST = 1'b0;
        drive2(1'b1, 1'b0, 32'h200, 32'h0);
        repeat (3) step();
        n_total++; if (if2.ramstate !== ACCESS) $display("FAIL rmid_rd_state: got %0d want %0d", if2.ramstate, ACCESS); else n_pass++;
        n_total++; if (if2.ramload !== 32'h0) $display("FAIL rmid_discarded: got %h want %h", if2.ramload, 32'h0); else n_pass++;
        drive2(1'b1, 1'b0, 32'h40, 32'h0);
        repeat (3) step();
        n_total++; if (if2.ramload !== 32'hDEADBEEF) $display("FAIL rmid_kept: got %h want %h", if2.ramload, 32'hDEADBEEF); else n_pass++;
        drive2(1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_bounds();
`ifdef RAM_BOUNDS_CHECK_EN
        drive2(1'b1, 1'b0, 32'h2, 32'h0);
        step();
        n_total++; if (if2.ramstate !== ERROR) $display("FAIL bnd_misalign_state: got %0d want %0d", if2.ramstate, ERROR); else n_pass++;
        n_total++; if (if2.ramload !== 32'hBAD1BAD1) $display("FAIL bnd_misalign_load: got %h want %h", if2.ramload, 32'hBAD1BAD1); else n_pass++;
        drive2(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        n_total++; if (if2.ramstate !== FREE) $display("FAIL bnd_exit: got %0d want %0d", if2.ramstate, FREE); else n_pass++;
        drive2(1'b1, 1'b0, 32'h1040, 32'h0);
        step();
        n_total++; if (if2.ramstate !== ERROR) $display("FAIL bnd_range_state: got %0d want %0d", if2.ramstate, ERROR); else n_pass++;
        drive2(1'b0, 1'b0, 32'h0, 32'h0);
        step();
`else
        ramstate_t exp_seq [3] = '{BUSY, BUSY, ACCESS};
        drive2(1'b1, 1'b0, 32'h2, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (if2.ramstate !== exp_seq[i]) $display("FAIL nobnd_seq[%0d]: got %0d want %0d", i, if2.ramstate, exp_seq[i]); else n_pass++;
        end
        n_total++; if (if2.ramload !== 32'h0) $display("FAIL nobnd_mem0: got %h want %h", if2.ramload, 32'h0); else n_pass++;
        // 0x1040 wraps onto word 16, the word behind 0x40.
        drive2(1'b1, 1'b0, 32'h1040, 32'h0);
        repeat (3) step();
        n_total++; if (if2.ramload !== 32'hDEADBEEF) $display("FAIL nobnd_wrap: got %h want %h", if2.ramload, 32'hDEADBEEF); else n_pass++;
        drive2(1'b0, 1'b0, 32'h0, 32'h0);
        step();
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_abort();
        test_addr_change();
        test_held_request();
        test_back_to_back();
        test_reset_mid();
        test_bounds();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
